a_feed_ctrl: RTL and testbench
==============================

// Module: a_feed_ctrl
// PURPOSE
//  Downstream consumer of the A operand buffer. On start_i it reads len_i+1 consecutive
//  vectors from one A-buffer bank, absorbs the buffer's return data in a small FIFO, and
//  drives them into the systolic array's A edge with diagonal row skew.
//  The skew means row r of vector k appears r cycles after row 0 of vector k.
//  Throttled by array stall_i; signals done_o once the last element has left the skew pipe.
// PARAMETERS
//  SA_ROWS     8   systolic array rows (A lanes)
//  ELEM_W      8   bits per A element
//  LOAD_W      64  SA_ROWS*ELEM_W; equals SARRAY_LOAD_WIDTH
//  CNT_W       4   equals TMMA_CNT_WIDTH; vector address width
//  FIFO_DEPTH  4   return-data FIFO entries (power of 2, >=2)
// PORTS
//  clk                  in   1        clock
//  rst                  in   1        reset
//  start_i              in   1        start pulse; sampled only in IDLE
//  buf_id_i             in   1        A-buffer bank to read; captured with start_i
//  len_i                in   CNT_W    vector count minus 1; captured with start_i
//  stall_i              in   1        array stall; freezes FIFO pop and skew pipe
//  busy_o               out  1        high from the cycle after start accept until done_o
//  done_o               out  1        one-cycle pulse: job complete
//  rd_a_buf_valid_o     out  1        read request to A buffer
//  rd_a_buf_id_o        out  1        bank of request
//  rd_a_buf_addr_o      out  CNT_W    vector address of request
//  rd_a_buf_ret_valid_i in   1        A-buffer return valid; in order, latency >=1
//  rd_a_buf_ret_data_i  in   LOAD_W   returned vector; row r = bits [r*ELEM_W +: ELEM_W]
//  sa_a_valid_o         out  SA_ROWS  per-row valid into array
//  sa_a_data_o          out  LOAD_W   per-row skewed data into array
// BEHAVIOUR
//  Clock and reset: one clock; reset is asynchronous and active-high.
//  Reset: every output is 0; FSM=IDLE; all counters 0; FIFO empty; skew regs cleared.
//  Reset mid-job: the job is abandoned. Returns arriving while outstanding==0 are dropped.
//  FSM:
//   IDLE: start_i=1 -> ISSUE; latch buf_id_i, len_i; addr counter and issued count cleared.
//   ISSUE: a request issues when credit holds: outstanding + fifo_cnt < FIFO_DEPTH.
//    On issue: rd_a_buf_valid_o=1, addr=issue count, then the count increments.
//    After request len+1 has issued -> DRAIN.
//   DRAIN: wait until outstanding==0, FIFO empty, and all skew regs invalid -> DONE.
//   DONE: done_o=1 for one cycle -> IDLE. busy_o=1 in ISSUE and DRAIN.
//  start_i outside IDLE: ignored.
//  Request/return accounting:
//   outstanding +1 on issue, -1 on ret_valid; both in one cycle -> unchanged.
//   Credit guarantees the FIFO never overflows.
//  FIFO push: on ret_valid. Pop: when !stall_i and FIFO not empty. Push+pop same cycle
//   is allowed, including when full.
//  Skew pipe: row r has an r-stage shift of {valid, elem}; row 0 has zero added delay.
//   Each !stall_i cycle: a popped vector (or a bubble if the FIFO is empty) enters
//   every row stage 0, and all stages shift by one.
//   sa_a_* are registered. Row r output = stage-r contents, so pop to row-0 out = 1 cycle.
//   stall_i=1: pipe, outputs and FIFO head hold; requests still issue while credit allows.
//  Address counter is CNT_W+1 bits internally, so len_i=2^CNT_W-1 (16 vectors) has no
//   wrap ambiguity. rd_a_buf_addr_o = low CNT_W bits.
//  Latency: with stall_i=0 and return latency L, vector k row r is valid at
//   start accept + 1 + k + L + 1 + r cycles, with no credit stall.
// TESTING
//  T1 Basic job: len=3, id=1, L=1, no stall.
//   -> addr 0,1,2,3 on 4 consecutive cycles, id=1.
//   -> row0 shows v0..v3 consecutively; row7 shows the same values 7 cycles later.
//   -> done_o once, 1 cycle after row7 shows v3.
//  T2 Credit: FIFO_DEPTH=4, L=6, len=7.
//   -> never more than 4 requests unreturned; all 8 vectors delivered in order.
//  T3 Stall: stall_i=1 for 5 cycles mid-stream.
//   -> sa_a_* hold their values; no FIFO overflow.
//   -> output sequence identical to the unstalled run, shifted by 5 cycles.
//  T4 Full length: len=15.
//   -> 16 requests, addr 0..15; no wrap; done_o after row7 shows v15.
//  T5 start_i pulsed while busy -> ignored; latched id/len unchanged.
//  T6 rst asserted mid-ISSUE.
//   -> all outputs 0 immediately; late ret_valid dropped; a new job then runs clean.

Source files
------------

// File: rtl/a_feed_ctrl.sv
// A-operand feeder: fetches len+1 vectors from one A-buffer bank under FIFO credit,
// then pushes them into the systolic array edge with a one-cycle-per-row diagonal skew.
module a_feed_ctrl #(
    parameter int SA_ROWS    = 8,
    parameter int ELEM_W     = 8,
    parameter int LOAD_W     = SA_ROWS * ELEM_W,
    parameter int CNT_W      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                buf_id_i,
    input  logic [CNT_W-1:0]    len_i,
    input  logic                stall_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                rd_a_buf_valid_o,
    output logic                rd_a_buf_id_o,
    output logic [CNT_W-1:0]    rd_a_buf_addr_o,
    input  logic                rd_a_buf_ret_valid_i,
    input  logic [LOAD_W-1:0]   rd_a_buf_ret_data_i,
    output logic [SA_ROWS-1:0]  sa_a_valid_o,
    output logic [LOAD_W-1:0]   sa_a_data_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int EW    = ELEM_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
    state_t r_state, w_state_nxt;

    logic                r_buf_id;
    logic [CNT_W-1:0]    r_len;
    logic [CNT_W:0]      r_issue_cnt;
    logic [PTR_W:0]      r_outstanding;
    logic [PTR_W:0]      r_fifo_cnt;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [LOAD_W-1:0]   r_fifo_mem [FIFO_DEPTH];

    logic                w_credit, w_issue, w_last_issue;
    logic                w_ret, w_empty, w_pop, w_pop_mem, w_store;
    logic [LOAD_W-1:0]   w_head;
    logic [SA_ROWS-1:0]  w_row_busy;
    logic                w_pipe_idle;

    assign w_credit     = ({1'b0, r_outstanding} + {1'b0, r_fifo_cnt}) < (PTR_W+2)'(FIFO_DEPTH);
    assign w_issue      = (r_state == S_ISSUE) && w_credit;
    assign w_last_issue = w_issue && (r_issue_cnt == {1'b0, r_len});

    // Returns with nothing outstanding belong to an abandoned job and are dropped.
    assign w_ret     = rd_a_buf_ret_valid_i && (r_outstanding != '0);
    assign w_empty   = (r_fifo_cnt == '0);
    assign w_pop     = !stall_i && (!w_empty || w_ret);
    assign w_head    = w_empty ? rd_a_buf_ret_data_i : r_fifo_mem[r_rd_ptr];
    assign w_pop_mem = w_pop && !w_empty;
    assign w_store   = w_ret && !(w_empty && w_pop);

    assign rd_a_buf_valid_o = w_issue;
    assign rd_a_buf_id_o    = w_issue & r_buf_id;
    assign rd_a_buf_addr_o  = w_issue ? r_issue_cnt[CNT_W-1:0] : '0;

    // Contents on the output stage leave at the next advancing edge, so they need not be waited for.
    assign w_pipe_idle = ~|w_row_busy && (!stall_i || ~|sa_a_valid_o);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        case (r_state)
            S_IDLE:  if (start_i) w_state_nxt = S_ISSUE;
            S_ISSUE: begin
                busy_o = 1'b1;
                if (w_last_issue) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy_o = 1'b1;
                if ((r_outstanding == '0) && w_empty && w_pipe_idle) w_state_nxt = S_DONE;
            end
            default: begin
                done_o      = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf_id      <= 1'b0;
            r_len         <= '0;
            r_issue_cnt   <= '0;
            r_outstanding <= '0;
            r_fifo_cnt    <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else begin
            if (r_state == S_IDLE && start_i) begin
                r_buf_id    <= buf_id_i;
                r_len       <= len_i;
                r_issue_cnt <= '0;
            end else if (w_issue) begin
                r_issue_cnt <= r_issue_cnt + (CNT_W+1)'(1);
            end
            case ({w_issue, w_ret})
                2'b10:   r_outstanding <= r_outstanding + (PTR_W+1)'(1);
                2'b01:   r_outstanding <= r_outstanding - (PTR_W+1)'(1);
                default: r_outstanding <= r_outstanding;
            endcase
            case ({w_store, w_pop_mem})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + (PTR_W+1)'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - (PTR_W+1)'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
            if (w_store)   r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop_mem) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_store) r_fifo_mem[r_wr_ptr] <= rd_a_buf_ret_data_i;
    end

    // Skew pipe: row g is a (g+1)-deep shift of {valid, elem}; stage 0 in the LSBs.
    for (genvar g = 0; g < SA_ROWS; g++) begin : g_row
        logic [(g+1)*EW-1:0] r_sh;
        logic [EW-1:0]       w_in;

        assign w_in = {w_pop, w_pop ? w_head[g*ELEM_W +: ELEM_W] : {ELEM_W{1'b0}}};
        assign sa_a_valid_o[g]                 = r_sh[(g+1)*EW-1];
        assign sa_a_data_o[g*ELEM_W +: ELEM_W] = r_sh[(g+1)*EW-2 -: ELEM_W];

        if (g == 0) begin : g_first
            assign w_row_busy[g] = 1'b0;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)           r_sh <= '0;
                else if (!stall_i) r_sh <= w_in;
            end
        end else begin : g_rest
            logic w_inner;
            always_comb begin
                w_inner = 1'b0;
                for (int s = 0; s < g; s++) w_inner = w_inner | r_sh[s*EW + ELEM_W];
            end
            assign w_row_busy[g] = w_inner;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)           r_sh <= '0;
                else if (!stall_i) r_sh <= {r_sh[g*EW-1:0], w_in};
            end
        end
    end
endmodule

// File: tb/tb_a_feed_ctrl.sv
// Directed bench for a_feed_ctrl: models the A buffer with fixed return latency and
// scoreboards every request and every skewed row element against hand-derived values.
module tb_a_feed_ctrl;
    localparam int SA_ROWS = 8;
    localparam int ELEM_W  = 8;
    localparam int LOAD_W  = 64;
    localparam int CNT_W   = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start_i = 1'b0;
    logic               buf_id_i = 1'b0;
    logic [CNT_W-1:0]   len_i = '0;
    logic               stall_i = 1'b0;
    logic               rd_a_buf_ret_valid_i = 1'b0;
    logic [LOAD_W-1:0]  rd_a_buf_ret_data_i = '0;
    logic               busy_o, done_o, rd_a_buf_valid_o, rd_a_buf_id_o;
    logic [CNT_W-1:0]   rd_a_buf_addr_o;
    logic [SA_ROWS-1:0] sa_a_valid_o;
    logic [LOAD_W-1:0]  sa_a_data_o;

    a_feed_ctrl dut (
        .clk(clk), .rst(rst), .start_i(start_i), .buf_id_i(buf_id_i), .len_i(len_i),
        .stall_i(stall_i), .busy_o(busy_o), .done_o(done_o),
        .rd_a_buf_valid_o(rd_a_buf_valid_o), .rd_a_buf_id_o(rd_a_buf_id_o),
        .rd_a_buf_addr_o(rd_a_buf_addr_o), .rd_a_buf_ret_valid_i(rd_a_buf_ret_valid_i),
        .rd_a_buf_ret_data_i(rd_a_buf_ret_data_i), .sa_a_valid_o(sa_a_valid_o),
        .sa_a_data_o(sa_a_data_o)
    );

    always #5 clk = ~clk;

    typedef struct { int due; int addr; logic id; } req_t;
    req_t q[$];

    int checks = 0, errors = 0, cyc = 0;
    int n_vec = 0, n_issued = 0, tb_out = 0, lat = 1, start_cyc = 0;
    int done_cnt = 0, last7 = -100, adv = 0, last_req = 0;
    bit consec = 0;
    logic job_id = 1'b0;
    int row_k [SA_ROWS];
    int adv0 [16];
    logic [SA_ROWS-1:0] prev_v = '0;
    logic [LOAD_W-1:0]  prev_d = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [ELEM_W-1:0] elem(input logic id, input int k, input int r);
        logic [ELEM_W-1:0] v;
        v = {id, 4'(k), 3'(r)};
        return v;
    endfunction

    function automatic logic [LOAD_W-1:0] vec(input logic id, input int k);
        logic [LOAD_W-1:0] v;
        for (int r = 0; r < SA_ROWS; r++) v[r*ELEM_W +: ELEM_W] = elem(id, k, r);
        return v;
    endfunction

    // One cycle: observe mid-cycle, answer due reads, scoreboard the array edge.
    task automatic tick();
        req_t e;
        int   k;
        @(negedge clk);
        cyc++;
        if (rd_a_buf_valid_o) begin
            check("req_addr", 64'(rd_a_buf_addr_o), 64'(n_issued[CNT_W-1:0]));
            check("req_id", 64'(rd_a_buf_id_o), 64'(job_id));
            if (consec && n_issued > 0) check("req_gap", 64'(cyc), 64'(last_req + 1));
            last_req = cyc;
            n_issued++;
            tb_out++;
            check("credit", 64'(tb_out <= 4), 64'(1));
            e.due = cyc + lat; e.addr = int'(rd_a_buf_addr_o); e.id = rd_a_buf_id_o;
            q.push_back(e);
        end
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            rd_a_buf_ret_valid_i = 1'b1;
            rd_a_buf_ret_data_i  = vec(e.id, e.addr);
            tb_out--;
        end else begin
            rd_a_buf_ret_valid_i = 1'b0;
            rd_a_buf_ret_data_i  = {$urandom, $urandom};
        end
        if (stall_i) begin
            check("hold_v", 64'(sa_a_valid_o), 64'(prev_v));
            check("hold_d", sa_a_data_o, prev_d);
        end else begin
            adv++;
            for (int r = 0; r < SA_ROWS; r++) begin
                if (sa_a_valid_o[r]) begin
                    k = row_k[r];
                    check("row_order", 64'(k < n_vec), 64'(1));
                    if (k < n_vec) begin
                        check("row_data", 64'(sa_a_data_o[r*ELEM_W +: ELEM_W]), 64'(elem(job_id, k, r)));
                        if (r == 0) begin
                            adv0[k] = adv;
                            if (k == 0) check("lat0", 64'(cyc), 64'(start_cyc + 2 + lat));
                        end else begin
                            check("skew", 64'(adv), 64'(adv0[k] + r));
                        end
                        if (r == SA_ROWS-1) last7 = cyc;
                    end
                    row_k[r]++;
                end
            end
        end
        prev_v = sa_a_valid_o;
        prev_d = sa_a_data_o;
        if (done_o) begin
            done_cnt++;
            check("done_gap", 64'(cyc), 64'(last7 + 1));
        end
    endtask

    task automatic job_init(input logic id, input int len, input int l);
        job_id = id; n_vec = len + 1; lat = l; n_issued = 0; done_cnt = 0;
        last7 = -100; tb_out = 0;
        for (int r = 0; r < SA_ROWS; r++) row_k[r] = 0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 64'(busy_o), 64'(0));
        check({tag, "_done"}, 64'(done_o), 64'(0));
        check({tag, "_rdv"}, 64'(rd_a_buf_valid_o), 64'(0));
        check({tag, "_rdid"}, 64'(rd_a_buf_id_o), 64'(0));
        check({tag, "_rdaddr"}, 64'(rd_a_buf_addr_o), 64'(0));
        check({tag, "_sav"}, 64'(sa_a_valid_o), 64'(0));
        check({tag, "_sad"}, sa_a_data_o, 64'(0));
    endtask

    task automatic run_job(input logic id, input int len, input int l,
                           input int st_at, input int st_len, input bit poke);
        job_init(id, len, l);
        buf_id_i  = id;
        len_i     = CNT_W'(len);
        start_i   = 1'b1;
        start_cyc = cyc;
        tick();
        start_i  = 1'b0;
        buf_id_i = ~id;
        len_i    = CNT_W'(len + 5);
        check("busy_on", 64'(busy_o), 64'(1));
        for (int i = 0; i < 400 && done_cnt == 0; i++) begin
            start_i = poke && (i == 3);
            if (start_i) len_i = 4'd1;
            stall_i = (st_len > 0) && (i >= st_at) && (i < st_at + st_len);
            tick();
        end
        start_i = 1'b0;
        stall_i = 1'b0;
        check("done_seen", 64'(done_cnt), 64'(1));
        tick();
        check("busy_off", 64'(busy_o), 64'(0));
        check("done_once", 64'(done_cnt), 64'(1));
        check("issued", 64'(n_issued), 64'(n_vec));
        for (int r = 0; r < SA_ROWS; r++) check("row_cnt", 64'(row_k[r]), 64'(n_vec));
    endtask

    initial begin
        job_init(1'b0, -1, 1);
        repeat (3) tick();
        check_zero("rst");
        rst = 1'b0;
        tick();

        consec = 1;
        run_job(1'b1, 3, 1, 0, 0, 0);       // basic
        consec = 0;
        run_job(1'b0, 7, 6, 0, 0, 0);       // credit-limited
        run_job(1'b1, 15, 1, 6, 5, 0);      // stall mid-stream
        run_job(1'b0, 15, 2, 0, 0, 0);      // full length
        run_job(1'b1, 5, 2, 0, 0, 1);       // start while busy

        // Reset in the middle of ISSUE; in-flight returns arrive afterwards.
        job_init(1'b1, 7, 4);
        buf_id_i  = 1'b1;
        len_i     = 4'd7;
        start_i   = 1'b1;
        start_cyc = cyc;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        check("mid_busy", 64'(busy_o), 64'(1));
        rst = 1'b1;
        #1;
        check_zero("rst_mid");
        tick();
        rst = 1'b0;
        repeat (10) tick();
        check("drop_q", 64'(q.size()), 64'(0));
        check("drop_busy", 64'(busy_o), 64'(0));
        for (int r = 0; r < SA_ROWS; r++) check("drop_row", 64'(row_k[r]), 64'(0));

        run_job(1'b0, 2, 1, 0, 0, 0);       // clean job after reset

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
